// File: rtl/fpu_issue_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_issue_buffer_if
//  Purpose  : Dispatch, FPU and CDB handshake bundle for fpu_issue_buffer.
//  Revision : 1.0  initial release
// ============================================================================
interface fpu_issue_buffer_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [4:0]         in_op;
  logic [31:0]        in_a;
  logic [31:0]        in_b;
  logic [31:0]        in_c;
  logic [TAG_W-1:0]   in_tag;
  logic               fpu_start;
  logic [4:0]         fpu_op;
  logic [31:0]        fpu_a;
  logic [31:0]        fpu_b;
  logic [31:0]        fpu_c;
  logic               fpu_busy;
  logic               fpu_done;
  logic [31:0]        fpu_result;
  logic               fpu_exc;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_result;
  logic               out_exc;
  logic [TAG_W-1:0]   out_tag;
  logic [c_cnt_w-1:0] count;

  // Environment side: dispatch stage, FPU and CDB.
  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_c, in_tag,
    output fpu_busy, fpu_done, fpu_result, fpu_exc, out_ready,
    input  in_ready, fpu_start, fpu_op, fpu_a, fpu_b, fpu_c,
    input  out_valid, out_result, out_exc, out_tag, count
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_c, in_tag,
    input  fpu_busy, fpu_done, fpu_result, fpu_exc, out_ready,
    output in_ready, fpu_start, fpu_op, fpu_a, fpu_b, fpu_c,
    output out_valid, out_result, out_exc, out_tag, count
  );
endinterface
`default_nettype wire

// File: rtl/fpu_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_issue_buffer
//  Purpose  : In-order FP op queue feeding the FPU, result held for the CDB.
//             Define FPU_ISSUE_BYPASS_EN to let an op skip an empty queue.
//  Revision : 1.0  initial release
// ============================================================================
module fpu_issue_buffer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input wire clk,
  input wire rst_n,
  fpu_issue_buffer_if.slave bif
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  logic [4:0]         r_q_op  [DEPTH];
  logic [31:0]        r_q_a   [DEPTH];
  logic [31:0]        r_q_b   [DEPTH];
  logic [31:0]        r_q_c   [DEPTH];
  logic [TAG_W-1:0]   r_q_tag [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_cnt_w-1:0] r_count;

  state_t             r_state;
  logic               r_kill;
  logic               r_fpu_start;
  logic [4:0]         r_iss_op;
  logic [31:0]        r_iss_a;
  logic [31:0]        r_iss_b;
  logic [31:0]        r_iss_c;
  logic [TAG_W-1:0]   r_iss_tag;
  logic               r_out_valid;
  logic [31:0]        r_out_result;
  logic               r_out_exc;
  logic [TAG_W-1:0]   r_out_tag;

  logic w_full, w_empty, w_in_ready, w_push, w_can_issue, w_pop, w_bypass, w_enq;

  assign w_full      = (r_count == c_cnt_w'(DEPTH));
  assign w_empty     = (r_count == '0);
  assign w_in_ready  = rst_n && !w_full && !bif.flush;
  assign w_push      = bif.in_valid && w_in_ready;
  // A pending result blocks issue so the next done pulse always has a home.
  assign w_can_issue = (r_state == S_IDLE) && !r_out_valid && !bif.fpu_busy && !bif.flush;
  assign w_pop       = w_can_issue && !w_empty;
`ifdef FPU_ISSUE_BYPASS_EN
  assign w_bypass    = w_can_issue && w_empty && w_push;
`else
  assign w_bypass    = 1'b0;
`endif
  assign w_enq       = w_push && !w_bypass;

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_q_op[r_wr_ptr]  <= bif.in_op;
      r_q_a[r_wr_ptr]   <= bif.in_a;
      r_q_b[r_wr_ptr]   <= bif.in_b;
      r_q_c[r_wr_ptr]   <= bif.in_c;
      r_q_tag[r_wr_ptr] <= bif.in_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_state      <= S_IDLE;
      r_kill       <= 1'b0;
      r_fpu_start  <= 1'b0;
      r_iss_op     <= '0;
      r_iss_a      <= '0;
      r_iss_b      <= '0;
      r_iss_c      <= '0;
      r_iss_tag    <= '0;
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_exc    <= 1'b0;
      r_out_tag    <= '0;
    end else begin
      r_fpu_start <= 1'b0;

      if (bif.flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + c_cnt_w'(w_enq) - c_cnt_w'(w_pop);
      end

      if (w_pop) begin
        r_iss_op  <= r_q_op[r_rd_ptr];
        r_iss_a   <= r_q_a[r_rd_ptr];
        r_iss_b   <= r_q_b[r_rd_ptr];
        r_iss_c   <= r_q_c[r_rd_ptr];
        r_iss_tag <= r_q_tag[r_rd_ptr];
      end else if (w_bypass) begin
        r_iss_op  <= bif.in_op;
        r_iss_a   <= bif.in_a;
        r_iss_b   <= bif.in_b;
        r_iss_c   <= bif.in_c;
        r_iss_tag <= bif.in_tag;
      end

      if (bif.flush || (r_out_valid && bif.out_ready)) r_out_valid <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_pop || w_bypass) begin
            r_state     <= S_START;
            r_fpu_start <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          if (bif.flush) r_kill <= 1'b1;
        end
        S_WAIT: begin
          // The FPU cannot be aborted; a killed op is retired silently.
          if (bif.fpu_done) begin
            r_state <= S_IDLE;
            r_kill  <= 1'b0;
            if (!r_kill && !bif.flush) begin
              r_out_valid  <= 1'b1;
              r_out_result <= bif.fpu_result;
              r_out_exc    <= bif.fpu_exc;
              r_out_tag    <= r_iss_tag;
            end
          end else if (bif.flush) begin
            r_kill <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bif.in_ready   = w_in_ready;
  assign bif.fpu_start  = r_fpu_start;
  assign bif.fpu_op     = r_iss_op;
  assign bif.fpu_a      = r_iss_a;
  assign bif.fpu_b      = r_iss_b;
  assign bif.fpu_c      = r_iss_c;
  assign bif.out_valid  = r_out_valid;
  assign bif.out_result = r_out_result;
  assign bif.out_exc    = r_out_exc;
  assign bif.out_tag    = r_out_tag;
  assign bif.count      = r_count;
endmodule
`default_nettype wire

// File: tb/tb_fpu_issue_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_issue_buffer
//  Purpose  : Directed and random bench for fpu_issue_buffer with an FPU mock
//             and an in-order result scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fpu_issue_buffer;
  localparam int DEPTH = 4;
  localparam int TAG_W = 5;
  localparam logic [4:0] OP_FADD = 5'd0;
  localparam logic [4:0] OP_FSUB = 5'd1;
  localparam logic [4:0] OP_FMUL = 5'd2;
  localparam logic [4:0] OP_FDIV = 5'd3;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             exc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fpu_issue_buffer_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bif ();
  fpu_issue_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (.clk(clk), .rst_n(rst_n), .bif(bif));

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  int   fpu_lat = 2;
  int   epoch = 0;
  int   start_cnt = 0;
  bit   rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Stand-in FPU: known IEEE cases return real answers, anything else a hash.
  function automatic logic [32:0] fpu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] c);
    if (op == OP_FADD && a == 32'h3F800000 && b == 32'h40000000) return {1'b0, 32'h40400000};
    if (op == OP_FMUL && a == 32'h40000000 && b == 32'h40400000) return {1'b0, 32'h40C00000};
    if (op == OP_FDIV && b == 32'h0) return {1'b1, 32'h7F800000};
    return {^(a & b), a ^ {b[15:0], b[31:16]} ^ c ^ {27'd0, op}};
  endfunction

  always @(negedge clk) if (bif.fpu_start) start_cnt++;

  initial begin : fpu_resp
    logic [32:0] r;
    logic [4:0]  h_op;
    logic [31:0] h_a, h_b, h_c;
    int          lat, ep;
    bif.fpu_busy = 1'b0; bif.fpu_done = 1'b0; bif.fpu_result = '0; bif.fpu_exc = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && bif.fpu_start) begin
        h_op = bif.fpu_op; h_a = bif.fpu_a; h_b = bif.fpu_b; h_c = bif.fpu_c;
        r = fpu_model(h_op, h_a, h_b, h_c);
        lat = fpu_lat; ep = epoch;
        @(posedge clk); #1 bif.fpu_busy = 1'b1;
        for (int i = 0; i < lat; i++) begin
          @(negedge clk);
          if (ep == epoch)
            chk("fpu_hold", 128'({bif.fpu_op, bif.fpu_a, bif.fpu_b, bif.fpu_c}),
                128'({h_op, h_a, h_b, h_c}));
          @(posedge clk); #1;
        end
        bif.fpu_busy = 1'b0; bif.fpu_done = 1'b1;
        bif.fpu_result = r[31:0]; bif.fpu_exc = r[32];
        @(posedge clk); #1;
        bif.fpu_done = 1'b0; bif.fpu_result = '0; bif.fpu_exc = 1'b0;
      end
    end
  end

  always @(negedge clk) begin : cdb_mon
    exp_t e;
    if (rst_n && !bif.flush && bif.out_valid && bif.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("cdb_unexpected_result", 128'(1), 128'(0));
      end else begin
        e = exp_q.pop_front();
        chk("cdb_tag", 128'(bif.out_tag), 128'(e.tag));
        chk("cdb_result", 128'(bif.out_result), 128'(e.res));
        chk("cdb_exc", 128'(bif.out_exc), 128'(e.exc));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_rdy) bif.out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic push(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] c, input logic [TAG_W-1:0] tag);
    logic [32:0] r;
    int n = 0;
    bit acc = 1'b0;
    bif.in_valid = 1'b1; bif.in_op = op; bif.in_a = a; bif.in_b = b; bif.in_c = c; bif.in_tag = tag;
    r = fpu_model(op, a, b, c);
    while (!acc && n < 300) begin
      @(negedge clk);
      acc = bif.in_ready;
      tick();
      n++;
    end
    bif.in_valid = 1'b0;
    chk("push_accept", 128'(acc), 128'(1));
    if (acc) exp_q.push_back({tag, r[31:0], r[32]});
  endtask

  task automatic wait_out_valid(input string name, input int budget);
    int n = 0;
    @(negedge clk);
    while (!bif.out_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_out_valid"}, 128'(bif.out_valid), 128'(1));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    bif.out_ready = 1'b1;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk({name, "_drain"}, 128'(exp_q.size()), 128'(0));
    tick();
  endtask

  task automatic do_flush();
    bif.flush = 1'b1;
    tick();
    bif.flush = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_fpu_side"}, 128'({bif.fpu_start, bif.fpu_op, bif.fpu_a, bif.fpu_b, bif.fpu_c}), 128'(0));
    chk({name, "_cdb_side"}, 128'({bif.out_valid, bif.out_result, bif.out_exc, bif.out_tag,
                                   bif.count, bif.in_ready}), 128'(0));
  endtask

  initial begin : stim
    int sc, ov;
    bif.flush = 1'b0; bif.in_valid = 1'b0; bif.in_op = '0; bif.in_a = '0; bif.in_b = '0;
    bif.in_c = '0; bif.in_tag = '0; bif.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 128'(bif.in_ready), 128'(1));
    @(posedge clk); #1;

    // Single FADD: one start pulse, exact result
    fpu_lat = 3; bif.out_ready = 1'b0; sc = start_cnt;
    push(OP_FADD, 32'h3F800000, 32'h40000000, 32'h0, 5'd3);
    wait_out_valid("t1", 50);
    chk("t1_result", 128'(bif.out_result), 128'(32'h40400000));
    chk("t1_tag", 128'(bif.out_tag), 128'(3));
    chk("t1_exc", 128'(bif.out_exc), 128'(0));
    chk("t1_start_pulses", 128'(start_cnt - sc), 128'(1));
    @(posedge clk); #1;
    drain("t1", 50);

    // Long FDIV in flight, fill queue, fifth op held off
    fpu_lat = 40;
    push(OP_FDIV, $urandom, $urandom | 32'h1, $urandom, 5'd10);
    repeat (3) tick();
    for (int i = 0; i < 4; i++) push(OP_FADD + 5'(i), $urandom, $urandom, $urandom, 5'(11 + i));
    bif.in_valid = 1'b1; bif.in_tag = 5'd15;
    @(negedge clk);
    chk("t2_count_full", 128'(bif.count), 128'(4));
    chk("t2_in_ready_full", 128'(bif.in_ready), 128'(0));
    @(posedge clk); #1;
    fpu_lat = 2;
    push(OP_FMUL, $urandom, $urandom, $urandom, 5'd15);
    drain("t2", 400);

    // Pending result blocks issue; issue resumes right after the clear
    fpu_lat = 3; bif.out_ready = 1'b0;
    push(OP_FSUB, $urandom, $urandom, $urandom, 5'd20);
    push(OP_FADD, $urandom, $urandom, $urandom, 5'd21);
    wait_out_valid("t3", 50);
    sc = start_cnt;
    repeat (10) @(negedge clk);
    chk("t3_no_issue", 128'(start_cnt - sc), 128'(0));
    chk("t3_count", 128'(bif.count), 128'(1));
    @(posedge clk); #1 bif.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_start_clear_cycle", 128'(bif.fpu_start), 128'(0));
    @(negedge clk);
    chk("t3_start_after_clear", 128'(bif.fpu_start), 128'(1));
    @(posedge clk); #1;
    drain("t3", 50);

    // Flush while waiting with two queued
    fpu_lat = 10; bif.out_ready = 1'b1;
    push(OP_FDIV, $urandom, $urandom | 32'h1, $urandom, 5'd1);
    repeat (3) tick();
    push(OP_FADD, $urandom, $urandom, $urandom, 5'd2);
    push(OP_FADD, $urandom, $urandom, $urandom, 5'd3);
    @(negedge clk);
    chk("t4_count_before", 128'(bif.count), 128'(2));
    @(posedge clk); #1;
    do_flush();
    @(negedge clk);
    chk("t4_count_flushed", 128'(bif.count), 128'(0));
    ov = 0;
    repeat (20) begin
      @(negedge clk);
      if (bif.out_valid) ov++;
    end
    chk("t4_killed_result", 128'(ov), 128'(0));
    @(posedge clk); #1 bif.out_ready = 1'b0;
    push(OP_FMUL, 32'h40000000, 32'h40400000, 32'h0, 5'd4);
    wait_out_valid("t4", 50);
    chk("t4_fmul_result", 128'(bif.out_result), 128'(32'h40C00000));
    chk("t4_fmul_tag", 128'(bif.out_tag), 128'(4));
    @(posedge clk); #1;
    drain("t4", 50);

    // Divide by zero raises the exception flag
    fpu_lat = 4; bif.out_ready = 1'b0;
    push(OP_FDIV, 32'h3F800000, 32'h00000000, 32'h0, 5'd7);
    wait_out_valid("t5", 50);
    chk("t5_exc", 128'(bif.out_exc), 128'(1));
    chk("t5_tag", 128'(bif.out_tag), 128'(7));
    @(posedge clk); #1;
    drain("t5", 50);

    // Latency from an idle, empty buffer
    repeat (2) tick();
    push(OP_FSUB, $urandom, $urandom, $urandom, 5'd9);
    @(negedge clk);
`ifdef FPU_ISSUE_BYPASS_EN
    chk("t6_bypass_start", 128'(bif.fpu_start), 128'(1));
    chk("t6_bypass_count", 128'(bif.count), 128'(0));
`else
    chk("t6_queued_start", 128'(bif.fpu_start), 128'(0));
    chk("t6_queued_count", 128'(bif.count), 128'(1));
    @(negedge clk);
    chk("t6_late_start", 128'(bif.fpu_start), 128'(1));
    chk("t6_late_count", 128'(bif.count), 128'(0));
`endif
    @(posedge clk); #1;
    drain("t6", 50);

    // Reset mid-operation; the stale done must be ignored
    fpu_lat = 20;
    push(OP_FDIV, $urandom, $urandom | 32'h1, $urandom, 5'd12);
    repeat (5) tick();
    rst_n = 1'b0; epoch++; exp_q.delete();
    #1;
    chk_all_zero("t7_async_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ov = 0;
    repeat (40) begin
      @(negedge clk);
      if (bif.out_valid) ov++;
    end
    chk("t7_stale_done", 128'(ov), 128'(0));
    chk("t7_count", 128'(bif.count), 128'(0));
    @(posedge clk); #1;

    // Random traffic with random back-pressure, latency and flushes
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      fpu_lat = $urandom_range(1, 6);
      if ($urandom_range(0, 15) == 0) do_flush();
      else push(5'($urandom_range(0, 25)), $urandom, $urandom, $urandom, 5'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    rnd_rdy = 1'b0;
    drain("random", 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
